// File: rtl/i2c_arb_if.sv
// Signal bundle between the I2C arbiter, its requesters and the shared I2C
// controller. The arbiter uses the slave modport; whatever drives requests
// and models the controller uses the master modport.
// arb_state mirrors the arbiter FSM state for observation.
interface i2c_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_tx_data;
    logic [NREQ-1:0]   req_feed;
    logic [NREQ-1:0]   req_rx_ack;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   req_busy;
    logic              req_tx_ack;
    logic [7:0]        req_rx_data;
    logic              wd_err;
    logic [7:0]        ctrl_addr;
    logic [7:0]        ctrl_tx_data;
    logic              ctrl_feed;
    logic              ctrl_rx_ack;
    logic              ctrl_rstn;
    logic              ctrl_busy;
    logic              ctrl_tx_ack;
    logic [7:0]        ctrl_rx_data;
    logic              ctrl_active;
    logic [1:0]        arb_state;

    modport slave (
        input  req, req_addr, req_tx_data, req_feed, req_rx_ack,
        input  ctrl_busy, ctrl_tx_ack, ctrl_rx_data, ctrl_active,
        output grant, req_busy, req_tx_ack, req_rx_data, wd_err,
        output ctrl_addr, ctrl_tx_data, ctrl_feed, ctrl_rx_ack, ctrl_rstn,
        output arb_state
    );

    modport master (
        output req, req_addr, req_tx_data, req_feed, req_rx_ack,
        output ctrl_busy, ctrl_tx_ack, ctrl_rx_data, ctrl_active,
        input  grant, req_busy, req_tx_ack, req_rx_data, wd_err,
        input  ctrl_addr, ctrl_tx_data, ctrl_feed, ctrl_rx_ack, ctrl_rstn,
        input  arb_state
    );
endinterface

// File: rtl/i2c_arb.sv
// Round-robin arbiter sharing one I2C controller between NREQ requesters,
// one grant per complete START..STOP transaction.
// Optional watchdog abort of hung transactions: define I2C_ARB_WATCHDOG_EN.
// Handshake: a requester holds req high until granted; once granted it owns
// the controller until ctrl_active drops (STOP or NACK), regardless of req.
module i2c_arb #(
    parameter int NREQ      = 2,
    parameter int PTR_W     = 3,
    parameter int WD_CYCLES = 200_000
) (
    input logic      clk,
    input logic      rstn,
    i2c_arb_if.slave bus
);
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_RUN    = 2'd2,
        ARB_DRAIN  = 2'd3
    } arb_state_t;

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [NREQ-1:0]  grant_q;
    logic [PTR_W-1:0] last;
    logic [PTR_W-1:0] winner;
    logic             any_req;
    logic             wd_hit;
    logic             abort_q;
    logic             owning;

    assign any_req = |bus.req;
    assign owning  = (state == ARB_LAUNCH) || (state == ARB_RUN);

    // Round-robin pick: first requester found starting at last+1, wrapping.
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = last;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req[i] && (i == (int'(last) + k) % NREQ)) begin
                    found  = 1'b1;
                    winner = PTR_W'(i);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic; ctrl_active is sampled on the rising edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (any_req) state_nxt = ARB_LAUNCH;
            ARB_LAUNCH: begin
                if (wd_hit)               state_nxt = ARB_DRAIN;
                else if (bus.ctrl_active) state_nxt = ARB_RUN;
            end
            ARB_RUN:    if (wd_hit || !bus.ctrl_active) state_nxt = ARB_DRAIN;
            ARB_DRAIN:  state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // Grant and round-robin pointer; grant held through DRAIN unless aborted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_q <= '0;
            last    <= PTR_W'(NREQ - 1);
        end else if (state == ARB_IDLE && any_req) begin
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            last    <= winner;
        end else if (wd_hit || state == ARB_DRAIN) begin
            grant_q <= '0;
        end
    end

    // FSM outputs: mux the owner onto the controller; idle/drain park feed high.
    always_comb begin
        bus.ctrl_addr    = 8'hFF;
        bus.ctrl_tx_data = 8'hFF;
        bus.ctrl_feed    = 1'b1;
        bus.ctrl_rx_ack  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (owning && last == PTR_W'(i)) begin
                bus.ctrl_addr    = bus.req_addr[8*i +: 8];
                bus.ctrl_tx_data = bus.req_tx_data[8*i +: 8];
                bus.ctrl_feed    = bus.req_feed[i];
                bus.ctrl_rx_ack  = bus.req_rx_ack[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req_busy[i] = grant_q[i] ? bus.ctrl_busy : 1'b1;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.req_tx_ack  = bus.ctrl_tx_ack;
    assign bus.req_rx_data = bus.ctrl_rx_data;
    assign bus.ctrl_rstn   = rstn & ~abort_q;
    assign bus.arb_state   = state;

`ifdef I2C_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            abort_hold;
    logic            wd_err_q;

    // Fires on the WD_CYCLES-th edge after the grant while still owning.
    assign wd_hit = owning && (wd_cnt == WD_W'(WD_CYCLES - 1));

    // Watchdog counter, abort stretcher (abort_q high for two cycles), error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt     <= '0;
            abort_q    <= 1'b0;
            abort_hold <= 1'b0;
            wd_err_q   <= 1'b0;
        end else begin
            wd_err_q <= wd_hit;
            if (state == ARB_IDLE && any_req) wd_cnt <= '0;
            else if (owning && !wd_hit)       wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_hit) begin
                abort_q    <= 1'b1;
                abort_hold <= 1'b1;
            end else if (abort_hold) begin
                abort_hold <= 1'b0;
            end else begin
                abort_q <= 1'b0;
            end
        end
    end

    assign bus.wd_err = wd_err_q;
`else
    assign wd_hit     = 1'b0;
    assign abort_q    = 1'b0;
    assign bus.wd_err = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_arb.sv
// Directed bench for i2c_arb with two requesters; the controller is modelled
// by driving ctrl_active / ctrl_busy by hand.
module tb_i2c_arb;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    i2c_arb_if #(.NREQ(2)) bus ();

    i2c_arb #(.NREQ(2), .PTR_W(3), .WD_CYCLES(50)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller goes active, later returns to idle; ends in ARB_IDLE.
    task automatic finish_txn();
        bus.ctrl_active = 1'b1;
        tick();
        bus.ctrl_active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.req          = 2'b00;
        bus.req_addr     = {8'h22, 8'h11};
        bus.req_tx_data  = {8'h44, 8'h33};
        bus.req_feed     = 2'b11;
        bus.req_rx_ack   = 2'b11;
        bus.ctrl_busy    = 1'b1;
        bus.ctrl_tx_ack  = 1'b0;
        bus.ctrl_rx_data = 8'h00;
        bus.ctrl_active  = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_feed", 32'(bus.ctrl_feed), 32'h1);
        chk("rst_addr", 32'(bus.ctrl_addr), 32'hFF);
        chk("rst_ctrl_rstn", 32'(bus.ctrl_rstn), 32'h0);
        chk("rst_wd_err", 32'(bus.wd_err), 32'h0);
        chk("rst_busy", 32'(bus.req_busy), 32'h3);
        chk("rst_state", 32'(bus.arb_state), 32'h0);
        rstn = 1'b1;
        tick();
        chk("idle_ctrl_rstn", 32'(bus.ctrl_rstn), 32'h1);
        chk("idle_grant", 32'(bus.grant), 32'h0);

        // Single request from requester 0
        bus.req = 2'b01;
        bus.req_addr[7:0] = 8'h90;
        bus.req_tx_data[7:0] = 8'h5A;
        bus.req_feed[0] = 1'b0;
        bus.req_rx_ack[0] = 1'b0;
        chk("pre_edge_grant", 32'(bus.grant), 32'h0);
        tick();
        chk("s_grant", 32'(bus.grant), 32'h1);
        chk("s_addr", 32'(bus.ctrl_addr), 32'h90);
        chk("s_tx", 32'(bus.ctrl_tx_data), 32'h5A);
        chk("s_feed", 32'(bus.ctrl_feed), 32'h0);
        chk("s_rx_ack", 32'(bus.ctrl_rx_ack), 32'h0);
        chk("s_state_launch", 32'(bus.arb_state), 32'h1);
        bus.ctrl_busy = 1'b0;
        bus.ctrl_rx_data = 8'hA5;
        bus.ctrl_tx_ack = 1'b1;
        #1;
        chk("s_busy_route", 32'(bus.req_busy), 32'h2);
        chk("s_rx_data", 32'(bus.req_rx_data), 32'hA5);
        chk("s_tx_ack", 32'(bus.req_tx_ack), 32'h1);
        bus.ctrl_busy = 1'b1;
        bus.ctrl_active = 1'b1;
        tick();
        chk("s_state_run", 32'(bus.arb_state), 32'h2);

        // Early deassert of req[0] plus late request from requester 1
        bus.req = 2'b10;
        bus.req_addr[15:8] = 8'hA2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_grant", 32'(bus.grant), 32'h1);
            chk("hold_addr", 32'(bus.ctrl_addr), 32'h90);
            chk("hold_busy1", 32'(bus.req_busy[1]), 32'h1);
        end
        bus.ctrl_active = 1'b0;
        tick();
        chk("drain_state", 32'(bus.arb_state), 32'h3);
        chk("drain_grant", 32'(bus.grant), 32'h1);
        chk("drain_feed", 32'(bus.ctrl_feed), 32'h1);
        tick();
        chk("gap_state", 32'(bus.arb_state), 32'h0);
        chk("gap_grant", 32'(bus.grant), 32'h0);
        chk("gap_feed", 32'(bus.ctrl_feed), 32'h1);
        chk("gap_addr", 32'(bus.ctrl_addr), 32'hFF);
        tick();
        chk("late_grant", 32'(bus.grant), 32'h2);
        chk("late_addr", 32'(bus.ctrl_addr), 32'hA2);
        chk("late_feed", 32'(bus.ctrl_feed), 32'h1);
        bus.req = 2'b00;
        finish_txn();
        chk("late_done_grant", 32'(bus.grant), 32'h0);
        tick();
        chk("noreq_grant", 32'(bus.grant), 32'h0);

        // Fairness with both requesting (last = 1)
        bus.req = 2'b11;
        tick();
        chk("rr_grant_0", 32'(bus.grant), 32'h1);
        finish_txn();
        chk("rr_gap", 32'(bus.grant), 32'h0);
        tick();
        chk("rr_grant_1", 32'(bus.grant), 32'h2);
        finish_txn();
        tick();
        chk("rr_grant_0b", 32'(bus.grant), 32'h1);

        // Reset mid-transaction, no clock edge
        bus.ctrl_active = 1'b1;
        tick();
        chk("mid_state_run", 32'(bus.arb_state), 32'h2);
        rstn = 1'b0;
        #2;
        chk("mid_rst_grant", 32'(bus.grant), 32'h0);
        chk("mid_rst_feed", 32'(bus.ctrl_feed), 32'h1);
        chk("mid_rst_ctrl_rstn", 32'(bus.ctrl_rstn), 32'h0);
        chk("mid_rst_state", 32'(bus.arb_state), 32'h0);
        bus.ctrl_active = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_grant", 32'(bus.grant), 32'h1);

`ifdef I2C_ARB_WATCHDOG_EN
        // Hung transaction: ctrl_active never rises; abort on the 50th edge
        for (int i = 1; i < 50; i++) begin
            tick();
            chk("wd_quiet_err", 32'(bus.wd_err), 32'h0);
            chk("wd_quiet_rstn", 32'(bus.ctrl_rstn), 32'h1);
        end
        chk("wd_pre_grant", 32'(bus.grant), 32'h1);
        tick();
        chk("wd_err_pulse", 32'(bus.wd_err), 32'h1);
        chk("wd_abort_rstn1", 32'(bus.ctrl_rstn), 32'h0);
        chk("wd_abort_grant", 32'(bus.grant), 32'h0);
        chk("wd_abort_state", 32'(bus.arb_state), 32'h3);
        tick();
        chk("wd_err_end", 32'(bus.wd_err), 32'h0);
        chk("wd_abort_rstn2", 32'(bus.ctrl_rstn), 32'h0);
        chk("wd_idle_state", 32'(bus.arb_state), 32'h0);
        tick();
        chk("wd_rstn_back", 32'(bus.ctrl_rstn), 32'h1);
        chk("wd_next_grant", 32'(bus.grant), 32'h2);
`else
        // Without the watchdog a stalled transaction is held indefinitely
        repeat (60) tick();
        chk("nowd_grant", 32'(bus.grant), 32'h1);
        chk("nowd_err", 32'(bus.wd_err), 32'h0);
        chk("nowd_rstn", 32'(bus.ctrl_rstn), 32'h1);
        chk("nowd_state", 32'(bus.arb_state), 32'h1);
        finish_txn();
        tick();
        chk("nowd_next_grant", 32'(bus.grant), 32'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_arb.md
# i2c_arb

Round-robin arbiter that shares one I2C controller between `NREQ` requesters. It grants the controller to one requester per complete I2C transaction (START through STOP). While a requester is granted, the arbiter multiplexes that requester's address, transmit data, feed and receive-ack onto the controller, and returns byte-boundary status to it alone. It sits between the controller and client blocks such as sensor pollers and configuration loaders, and includes an optional watchdog that aborts a hung transaction.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, range 2..8.
- `PTR_W`, default 3: width of the requester index; must satisfy `2**PTR_W >= NREQ`.
- `WD_CYCLES`, default 200_000: watchdog limit in `clk` cycles.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  per-requester transaction request, active-high.
- `req_addr`  in  8*NREQ  address byte (7-bit address + R/W in bit 0); requester i occupies bits [8i+7:8i].
- `req_tx_data`  in  8*NREQ  transmit byte, same packing as `req_addr`.
- `req_feed`  in  NREQ  active-low: low = continue with another byte.
- `req_rx_ack`  in  NREQ  ack value to drive after a received byte.
- `grant`  out  NREQ  one-hot grant, or all zero.
- `req_busy`  out  NREQ  controller busy flag, routed to the granted requester only; the others see 1.
- `req_tx_ack`  out  1  slave ack bit, shared.
- `req_rx_data`  out  8  received byte, shared; valid only for the granted requester.
- `wd_err`  out  1  one-cycle pulse when the watchdog aborts.
- `ctrl_addr`, `ctrl_tx_data`  out  8  to controller.
- `ctrl_feed`  out  1  to controller, active-low.
- `ctrl_rx_ack`  out  1  to controller.
- `ctrl_rstn`  out  1  controller reset, active-low.
- `ctrl_busy`  in  1  from controller; low at byte boundaries, START and STOP.
- `ctrl_tx_ack`  in  1  from controller.
- `ctrl_rx_data`  in  8  from controller.
- `ctrl_active`  in  1  high while the controller is outside its idle state.

## Operation
State machine with four states:
- `ARB_IDLE`: all `grant` bits low; `ctrl_feed` = 1; `ctrl_addr` / `ctrl_tx_data` = 0xFF.
  - If any `req` is high, choose the winner by round-robin. The search starts at `last+1` and wraps modulo `NREQ`.
  - Register `grant`, set `last` to the winner, and go to `ARB_LAUNCH`.
- `ARB_LAUNCH`: forward the winner's `req_addr`, `req_tx_data`, `req_rx_ack` and `req_feed` to the controller.
  - Go to `ARB_RUN` on the first cycle in which `ctrl_active` is sampled high.
- `ARB_RUN`: keep forwarding the winner's signals.
  - Go to `ARB_DRAIN` on the first cycle in which `ctrl_active` is sampled low.
- `ARB_DRAIN`: force `ctrl_feed` = 1 for one cycle, so the controller cannot restart on a stale feed, then go to `ARB_IDLE`.
  - `grant` stays high through this cycle.

Rules:
- Once a grant is issued, deasserting `req` has no effect. The requester ends its transaction only by driving `req_feed` high at a byte boundary, or by NACK from the slave.
- Requests that arrive while a grant is held wait their turn; none are dropped. `req` is level-sensitive.
- Fairness: with all `NREQ` requesting continuously, grants cycle 0,1,…,NREQ-1,0,….
- `ctrl_rstn` = `rstn` AND NOT `abort_q`. `abort_q` is a registered bit.
- `req_tx_ack` and `req_rx_data` pass through combinationally.

Reset and abort:
- Reset values: `grant` = 0, `last` = NREQ-1 (so requester 0 wins first), `wd_err` = 0, `abort_q` = 0, state = `ARB_IDLE`.
- Reset mid-transaction clears the grant immediately (asynchronously). The controller is reset through `ctrl_rstn`.

## Timing
- `req` high in `ARB_IDLE` at edge n gives `grant` high after edge n (latency 1 cycle).
- Controller outputs are driven by the winner's inputs starting in the same cycle that `grant` rises.
- `ctrl_active` falling at edge m gives state `ARB_DRAIN` after m and state `ARB_IDLE` after m+1.
  - The earliest next grant is visible after edge m+2.
- Minimum gap between successive transactions: 2 idle cycles of `ctrl_feed` = 1.
- The state machine samples controller status on the rising edge of `clk`. The controller updates on the falling edge, so there is half a cycle of settling.
- Simultaneous `req` rising and `ctrl_active` falling: the request is served from `ARB_IDLE`, never from `ARB_DRAIN`.

## Configuration
- `I2C_ARB_WATCHDOG_EN` defined:
  - The counter `wd_cnt` has width `$clog2(WD_CYCLES+1)` and is cleared on entry to `ARB_LAUNCH`.
  - It counts every cycle in `ARB_LAUNCH` and `ARB_RUN`.
  - When it reaches `WD_CYCLES`: `abort_q` = 1 for 2 cycles, `wd_err` pulses for 1 cycle, `grant` clears, state goes to `ARB_DRAIN`, and `last` still advances.
- Not defined: there is no counter, `wd_err` is tied to 0, `abort_q` is tied to 0, and `ctrl_rstn` = `rstn`.

## Test plan
- **Single request:** `req` = 01, `req_addr[7:0]` = 0x90, `req_feed[0]` = 0 → `grant` = 01 after 1 cycle; `ctrl_addr` = 0x90; `grant` drops 2 cycles after `ctrl_active` falls.
- **Simultaneous requests from reset:** `req` = 11 → `grant` = 01 first, then 10, then 01 again while both stay high.
- **Late request:** `req[1]` rises during requester 0's `ARB_RUN` → no change to `grant` or `ctrl_*` until drain; then `grant` = 10.
- **Early deassert:** `req[0]` deasserted in `ARB_RUN`, `req_feed[0]` held 0 → `grant` = 01 held until `ctrl_active` = 0; `req_busy[1]` stays 1 throughout.
- **Reset mid-transaction:** `rstn` low during `ARB_RUN` → `grant` = 0, `ctrl_feed` = 1 and `ctrl_rstn` = 0 with no clock edge; after release, requester 0 wins first.
- **Watchdog** (macro on, `WD_CYCLES` = 50): `ctrl_active` held 0 after grant → at cycle 50 `wd_err` pulses once, `ctrl_rstn` is low for 2 cycles, and the next grant goes to requester 1.
